// File: rtl/quadrilatero_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : quadrilatero_dispatch_pkg
// Purpose  : Shared types and width helpers for the Quadrilatero row
//            dispatcher and its one-hot compaction network.
// Contents : id_w()/row_w() width helpers, issue_lane_t lane record,
//            req_state_e per-requester state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package quadrilatero_dispatch_pkg;

   // Storage width of the lane record fields; instances narrow on output.
   localparam int c_ID_W_MAX  = 8;
   localparam int c_ROW_W_MAX = 8;

   function automatic int id_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

   function automatic int row_w(input int n_rows);
      return (n_rows > 1) ? $clog2(n_rows) : 1;
   endfunction

   typedef struct packed {
      logic                   valid;
      logic [c_ID_W_MAX-1:0]  id;
      logic [c_ROW_W_MAX-1:0] row;
   } issue_lane_t;

   typedef enum logic [0:0] {
      REQ_IDLE   = 1'b0,
      REQ_ACTIVE = 1'b1
   } req_state_e;

endpackage
`default_nettype wire

// File: rtl/quadrilatero_onehot_compact.sv
`default_nettype none
// ============================================================================
// Module   : quadrilatero_onehot_compact
// Purpose  : Combinational compaction of the set bits of a WIDTH-bit vector
//            onto NumActOut entries, lowest index first.
// Ports    : vec_i   - input vector to compact
//            valid_o - entry k holds a set bit
//            idx_o   - flattened NumActOut x IdW bit indices
//            taken_o - mask of the bits that found an entry
// Revision : 1.0 - initial release
// ============================================================================
module quadrilatero_onehot_compact
   import quadrilatero_dispatch_pkg::*;
#(
   parameter int  WIDTH     = 8,
   parameter int  NumActOut = 3,
   localparam int IdW       = id_w(WIDTH)
) (
   input  logic [WIDTH-1:0]         vec_i,
   output logic [NumActOut-1:0]     valid_o,
   output logic [NumActOut*IdW-1:0] idx_o,
   output logic [WIDTH-1:0]         taken_o
);

   // rank counts set bits below position i; a bit lands on entry 'rank'
   // and bits ranked NumActOut or higher are left untaken.
   always_comb begin
      int rank;
      valid_o = '0;
      idx_o   = '0;
      taken_o = '0;
      rank    = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (vec_i[i]) begin
            for (int k = 0; k < NumActOut; k++) begin
               if (rank == k) begin
                  valid_o[k]             = 1'b1;
                  idx_o[k*IdW +: IdW]    = IdW'(i);
                  taken_o[i]             = 1'b1;
               end
            end
            rank = rank + 1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/quadrilatero_row_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : quadrilatero_row_dispatcher
// Purpose  : Requester-side companion of the round-robin row arbiter. Holds
//            one N_ROWS-row job per requester, requests while active, and
//            compacts same-cycle grants onto NumActOut registered issue lanes.
// Ports    : clk_i, rst_ni (async active-low)
//            job_valid_i/job_ready_o - per-requester job handshake
//            req_o/grant_i           - arbiter request/grant (grant is
//                                      combinational on req_o)
//            issue_valid_o/issue_id_o/issue_row_o - issue lanes
//            issue_ready_i           - datapath accepts all valid lanes
//            done_o                  - one-cycle last-row completion pulse
//            err_o                   - sticky protocol error
// Config   : QUADRILATERO_DISPATCH_CHECK_EN enables grant protocol checking
//            (err_o plus simulation assertions); otherwise err_o is 0.
// Revision : 1.0 - initial release
// ============================================================================
module quadrilatero_row_dispatcher
   import quadrilatero_dispatch_pkg::*;
#(
   parameter int  NumActOut = 3,
   parameter int  N_ROWS    = 4,
   parameter int  WIDTH     = 8,
   localparam int IdW       = id_w(WIDTH),
   localparam int RowW      = row_w(N_ROWS)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [WIDTH-1:0]          job_valid_i,
   output logic [WIDTH-1:0]          job_ready_o,
   output logic [WIDTH-1:0]          req_o,
   input  logic [WIDTH-1:0]          grant_i,
   output logic [NumActOut-1:0]      issue_valid_o,
   output logic [NumActOut*IdW-1:0]  issue_id_o,
   output logic [NumActOut*RowW-1:0] issue_row_o,
   input  logic                      issue_ready_i,
   output logic [WIDTH-1:0]          done_o,
   output logic                      err_o
);

   localparam logic [RowW-1:0] c_ROW_LAST = RowW'(N_ROWS - 1);

   req_state_e       r_state [WIDTH];
   logic [RowW-1:0]  r_row   [WIDTH];
   logic             r_done  [WIDTH];
   issue_lane_t      r_lane  [NumActOut];

   logic                     w_stall;
   logic [WIDTH-1:0]         w_cap;
   logic [WIDTH-1:0]         w_taken;
   logic [NumActOut-1:0]     w_lane_valid;
   logic [NumActOut*IdW-1:0] w_lane_idx;

   // Held lanes block both new requests and grant capture.
   assign w_stall = (|issue_valid_o) & ~issue_ready_i;
   assign w_cap   = grant_i & req_o;

   quadrilatero_onehot_compact #(
      .WIDTH     (WIDTH),
      .NumActOut (NumActOut)
   ) u_compact (
      .vec_i   (w_cap),
      .valid_o (w_lane_valid),
      .idx_o   (w_lane_idx),
      .taken_o (w_taken)
   );

   // ---------------------------------------------------------------- requesters
   for (genvar i = 0; i < WIDTH; i++) begin : g_req
      req_state_e      w_state_nxt;
      logic [RowW-1:0] w_row_nxt;
      logic            w_done_nxt;

      // Only taken grants advance the row, so dropped or spurious grants
      // leave the requester untouched.
      always_comb begin
         w_state_nxt = r_state[i];
         w_row_nxt   = r_row[i];
         w_done_nxt  = 1'b0;
         case (r_state[i])
            REQ_IDLE: begin
               if (job_valid_i[i]) begin
                  w_state_nxt = REQ_ACTIVE;
                  w_row_nxt   = '0;
               end
            end
            REQ_ACTIVE: begin
               if (w_taken[i]) begin
                  if (r_row[i] == c_ROW_LAST) begin
                     w_state_nxt = REQ_IDLE;
                     w_row_nxt   = '0;
                     w_done_nxt  = 1'b1;
                  end else begin
                     w_row_nxt = r_row[i] + RowW'(1);
                  end
               end
            end
            default: w_state_nxt = REQ_IDLE;
         endcase
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_state[i] <= REQ_IDLE;
            r_row[i]   <= '0;
            r_done[i]  <= 1'b0;
         end else begin
            r_state[i] <= w_state_nxt;
            r_row[i]   <= w_row_nxt;
            r_done[i]  <= w_done_nxt;
         end
      end

      assign job_ready_o[i] = (r_state[i] == REQ_IDLE);
      assign req_o[i]       = (r_state[i] == REQ_ACTIVE) & ~w_stall;
      assign done_o[i]      = r_done[i];
   end

   // ---------------------------------------------------------------- lanes
   for (genvar k = 0; k < NumActOut; k++) begin : g_lane
      logic [IdW-1:0]  w_id;
      logic [RowW-1:0] w_row;
      logic            w_lane_unused;

      assign w_id  = w_lane_idx[k*IdW +: IdW];
      assign w_row = w_lane_valid[k] ? r_row[w_id] : '0;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_lane[k] <= '0;
         end else if (!w_stall) begin
            r_lane[k].valid <= w_lane_valid[k];
            r_lane[k].id    <= c_ID_W_MAX'(w_id);
            r_lane[k].row   <= c_ROW_W_MAX'(w_row);
         end
      end

      assign issue_valid_o[k]             = r_lane[k].valid;
      assign issue_id_o[k*IdW +: IdW]     = r_lane[k].id[IdW-1:0];
      assign issue_row_o[k*RowW +: RowW]  = r_lane[k].row[RowW-1:0];
      // Upper record bits stay zero; fold them so they are consumed.
      assign w_lane_unused                = ^r_lane[k];
   end

   // ---------------------------------------------------------------- checking
`ifdef QUADRILATERO_DISPATCH_CHECK_EN
   logic w_err_no_req;
   logic w_err_over;
   logic w_err_stall;
   logic r_err;

   assign w_err_no_req = |(grant_i & ~req_o);
   assign w_err_over   = ($countones(grant_i) > NumActOut);
   assign w_err_stall  = w_stall & (|grant_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_err <= 1'b0;
      end else if (w_err_no_req | w_err_over | w_err_stall) begin
         r_err <= 1'b1;
      end
   end

   assign err_o = r_err;

   a_grant_no_req : assert property (@(posedge clk_i) disable iff (!rst_ni) !w_err_no_req)
      else $warning("grant without matching request");
   a_grant_over   : assert property (@(posedge clk_i) disable iff (!rst_ni) !w_err_over)
      else $warning("more grants than issue lanes");
   a_grant_stall  : assert property (@(posedge clk_i) disable iff (!rst_ni) !w_err_stall)
      else $warning("grant while stalled");
`else
   assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire
